rect_fill_ctrl: RTL and testbench

RECT_FILL_CTRL -- requirements
Module: rect_fill_ctrl

---
 rtl/rect_fill_ctrl.sv | 132 +++++++++++++
 tb/tb_rect_fill_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_fill_ctrl.sv
// Rectangle fill controller: clips a requested rectangle to the screen and
// streams its pixels in raster order to a VGA adapter, one pixel per cycle.
module rect_fill_ctrl #(
  parameter int SCREEN_WIDTH  = 160,
  parameter int SCREEN_HEIGHT = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] x0,
  input  logic [6:0] y0,
  input  logic [7:0] w,
  input  logic [6:0] h,
  input  logic [2:0] colour_in,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

  localparam logic [8:0] X_LIM = 9'(SCREEN_WIDTH);
  localparam logic [8:0] Y_LIM = 9'(SCREEN_HEIGHT);
  localparam logic [8:0] X_MAX = 9'(SCREEN_WIDTH - 1);
  localparam logic [8:0] Y_MAX = 9'(SCREEN_HEIGHT - 1);

  state_t     state;
  logic [7:0] x0_reg;
  logic [8:0] xend;
  logic [8:0] yend;

  logic [8:0] x_sum;
  logic [8:0] y_sum;
  logic [8:0] xend_calc;
  logic [8:0] yend_calc;
  logic       empty_rect;
  logic       last_col;
  logic       last_row;

  // Bounds are widened to 9 bits so x0+w-1 cannot wrap before clipping.
  always_comb begin
    x_sum      = {1'b0, x0} + {1'b0, w} - 9'd1;
    y_sum      = {2'b00, y0} + {2'b00, h} - 9'd1;
    xend_calc  = (x_sum > X_MAX) ? X_MAX : x_sum;
    yend_calc  = (y_sum > Y_MAX) ? Y_MAX : y_sum;
    empty_rect = (w == 8'd0) || (h == 7'd0) ||
                 ({1'b0, x0} >= X_LIM) || ({2'b00, y0} >= Y_LIM);
    last_col   = ({1'b0, x} == xend);
    last_row   = ({2'b00, y} == yend);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      x0_reg <= 8'd0;
      xend   <= 9'd0;
      yend   <= 9'd0;
      x      <= 8'd0;
      y      <= 7'd0;
      colour <= 3'd0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          plot <= 1'b0;
          done <= 1'b0;
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        LOAD: begin
          colour <= colour_in;
          x0_reg <= x0;
          xend   <= xend_calc;
          yend   <= yend_calc;
          busy   <= 1'b1;
          if (empty_rect) begin
            state <= DONE;
            plot  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= DRAW;
            x     <= x0;
            y     <= y0;
            plot  <= 1'b1;
            done  <= 1'b0;
          end
        end
        DRAW: begin
          busy <= 1'b1;
          // The pixel on screen this cycle is plotted even when abort is seen.
          if (abort || (last_col && last_row)) begin
            state <= DONE;
            plot  <= 1'b0;
            done  <= 1'b1;
          end else if (last_col) begin
            x    <= x0_reg;
            y    <= y + 7'd1;
            plot <= 1'b1;
            done <= 1'b0;
          end else begin
            x    <= x + 8'd1;
            plot <= 1'b1;
            done <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          plot  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          plot  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_ctrl.sv
// Scoreboard bench for rect_fill_ctrl: stimulus pushes expected pixels and
// done pulses (with cycle stamps); a negedge monitor pops and compares.
module tb_rect_fill_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [7:0] w;
  logic [6:0] h;
  logic [2:0] colour_in;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  typedef struct {
    int cyc;
    int px;
    int py;
    int pc;
  } pix_t;

  typedef struct {
    int cyc;
    int busy_len;
  } done_t;

  pix_t  pix_q[$];
  done_t done_q[$];

  int cyc;
  int busy_run;
  int checks;
  int fails;

  rect_fill_ctrl #(
    .SCREEN_WIDTH (160),
    .SCREEN_HEIGHT(120)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .x0       (x0),
    .y0       (y0),
    .w        (w),
    .h        (h),
    .colour_in(colour_in),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every plot and done strobe must match the head of its queue.
  always @(negedge clk) begin
    pix_t  pe;
    done_t de;
    if (reset) busy_run = 0;
    else if (busy) busy_run = busy_run + 1;
    else busy_run = 0;

    if (plot) begin
      checks = checks + 1;
      if (pix_q.size() == 0) begin
        fails = fails + 1;
        $display("[TB] FAIL unexpected_plot: got cyc=%0d (%0d,%0d) c=%0d, required no plot",
                 cyc, x, y, colour);
      end else begin
        pe = pix_q.pop_front();
        if (pe.cyc != cyc || pe.px != int'(x) || pe.py != int'(y) || pe.pc != int'(colour)) begin
          fails = fails + 1;
          $display("[TB] FAIL pixel: got cyc=%0d (%0d,%0d) c=%0d, required cyc=%0d (%0d,%0d) c=%0d",
                   cyc, x, y, colour, pe.cyc, pe.px, pe.py, pe.pc);
        end
      end
    end

    if (done) begin
      checks = checks + 1;
      if (done_q.size() == 0) begin
        fails = fails + 1;
        $display("[TB] FAIL unexpected_done: got done at cyc=%0d, required none", cyc);
      end else begin
        de = done_q.pop_front();
        if (de.cyc != cyc || de.busy_len != busy_run || pix_q.size() != 0) begin
          fails = fails + 1;
          $display("[TB] FAIL done_pulse: got cyc=%0d busy_len=%0d pending_pix=%0d, required cyc=%0d busy_len=%0d pending_pix=0",
                   cyc, busy_run, pix_q.size(), de.cyc, de.busy_len);
        end
      end
    end
  end

  task automatic check_output(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      fails = fails + 1;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_x"}, int'(x), 0);
    check_output({tag, "_y"}, int'(y), 0);
    check_output({tag, "_colour"}, int'(colour), 0);
    check_output({tag, "_plot"}, int'(plot), 0);
    check_output({tag, "_busy"}, int'(busy), 0);
    check_output({tag, "_done"}, int'(done), 0);
  endtask

  // abort_at: abort during the Nth DRAW cycle; reset_at: reset in Nth DRAW cycle.
  task automatic apply_stimulus(input int ax0, input int ay0, input int aw, input int ah,
                                input int ac, input int abort_at, input int reset_at);
    int s;
    int xe;
    int ye;
    int n;
    int limit;
    bit degen;
    @(posedge clk);
    #1;
    s         = cyc;
    x0        = 8'(ax0);
    y0        = 7'(ay0);
    w         = 8'(aw);
    h         = 7'(ah);
    colour_in = 3'(ac);
    start     = 1'b1;

    xe    = (ax0 + aw - 1 > 159) ? 159 : ax0 + aw - 1;
    ye    = (ay0 + ah - 1 > 119) ? 119 : ay0 + ah - 1;
    degen = (aw == 0) || (ah == 0) || (ax0 >= 160) || (ay0 >= 120);
    limit = (abort_at > 0) ? abort_at : (reset_at > 0) ? reset_at - 1 : 1 << 30;
    n     = 0;
    if (!degen) begin
      for (int yy = ay0; yy <= ye; yy++) begin
        for (int xx = ax0; xx <= xe; xx++) begin
          if (n < limit) begin
            pix_q.push_back('{s + 2 + n, xx, yy, ac});
            n++;
          end
        end
      end
    end
    if (reset_at == 0) done_q.push_back('{s + 2 + n, n + 2});

    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    x0        = 8'd77;
    y0        = 7'd5;
    w         = 8'd9;
    h         = 7'd9;
    colour_in = 3'(~ac);

    if (abort_at > 0) begin
      while (cyc < s + 1 + abort_at) begin
        @(posedge clk);
        #1;
      end
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
    end

    if (reset_at > 0) begin
      while (cyc < s + 1 + reset_at) begin
        @(posedge clk);
        #1;
      end
      reset = 1'b1;
      #1;
      check_reset_outputs("midreset");
      @(posedge clk);
      @(posedge clk);
      #1;
      check_output("midreset_hold_plot", int'(plot), 0);
      check_output("midreset_hold_done", int'(done), 0);
      reset = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      #2;
      if (pix_q.size() == 0 && done_q.size() == 0 && !busy) ok = 1'b1;
    end
    if (!ok) begin
      checks = checks + 1;
      fails  = fails + 1;
      $display("[TB] FAIL %s_timeout: got pending_pix=%0d pending_done=%0d busy=%0d, required all idle",
               name, pix_q.size(), done_q.size(), busy);
      pix_q.delete();
      done_q.delete();
    end
  endtask

  initial begin
    cyc       = 0;
    busy_run  = 0;
    checks    = 0;
    fails     = 0;
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    x0        = 8'd0;
    y0        = 7'd0;
    w         = 8'd0;
    h         = 7'd0;
    colour_in = 3'd0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] abort while idle has no effect");
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("idle_abort_busy", int'(busy), 0);

    $display("[TB] basic fill");
    apply_stimulus(10, 20, 3, 2, 4, 0, 0);
    wait_idle("basic", 50);
    check_output("basic_hold_x", int'(x), 12);
    check_output("basic_hold_y", int'(y), 21);
    check_output("basic_hold_colour", int'(colour), 4);

    $display("[TB] clipping");
    apply_stimulus(158, 118, 4, 4, 2, 0, 0);
    wait_idle("clip", 50);

    $display("[TB] degenerate inputs");
    apply_stimulus(10, 10, 0, 5, 1, 0, 0);
    wait_idle("w_zero", 20);
    apply_stimulus(160, 10, 5, 5, 1, 0, 0);
    wait_idle("x0_off", 20);
    apply_stimulus(10, 120, 5, 5, 1, 0, 0);
    wait_idle("y0_off", 20);

    $display("[TB] full screen with start pulsed during draw");
    apply_stimulus(0, 0, 255, 127, 5, 0, 0);
    repeat (100) @(posedge clk);
    #1;
    x0        = 8'd3;
    y0        = 7'd3;
    w         = 8'd2;
    h         = 7'd2;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle("full", 25000);
    check_output("full_last_x", int'(x), 159);
    check_output("full_last_y", int'(y), 119);

    $display("[TB] abort in the 6th draw cycle");
    apply_stimulus(0, 0, 4, 4, 6, 6, 0);
    wait_idle("abort", 50);
    check_output("abort_hold_x", int'(x), 1);
    check_output("abort_hold_y", int'(y), 1);

    $display("[TB] reset in the 3rd draw cycle");
    apply_stimulus(0, 0, 4, 4, 7, 0, 3);
    wait_idle("reset_mid", 50);
    apply_stimulus(20, 30, 2, 3, 3, 0, 0);
    wait_idle("after_reset", 50);

    repeat (3) @(posedge clk);
    #1;
    check_output("pix_q_empty", pix_q.size(), 0);
    check_output("done_q_empty", done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
